// File: rtl/spu_ls_pkg.sv
// spu_ls_pkg: shared types and default sizes for the SPU local-store port arbiter.
//   owner_e     - which requester a returned read beat belongs to
//   arb_state_e - arbiter FSM states
//   ret_tag_t   - tag carried down the read-return pipeline
package spu_ls_pkg;

    localparam int unsigned LS_AW_DEF    = 14;   // quadword address width (256KB / 16B)
    localparam int unsigned QW_DEF       = 128;  // quadword width in bits
    localparam int unsigned IF_BEATS_DEF = 4;    // quadwords per 64B instruction line
    localparam int unsigned BEAT_W       = 2;    // if_beat width; bounds IF_BEATS to 2..4

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DMA,
        OWN_LSU,
        OWN_IF
    } owner_e;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_e;

    typedef struct packed {
        logic              valid;
        owner_e            owner;
        logic [BEAT_W-1:0] beat;
    } ret_tag_t;

endpackage

// File: rtl/ls_ret_pipe.sv
// ls_ret_pipe: LS_LAT-deep shift register of read-return tags. A tag enters on every
// port strobe (valid=0 for writes/idle) and, when it reaches the last stage, is decoded
// into exactly one rvalid strobe for its owner, aligned with the LS read data.
//   clk, reset     - clock, synchronous active-high reset (clears all stages)
//   i_valid        - a read was strobed this cycle
//   i_owner        - owner of that read (owner_e encoding)
//   i_beat         - refill beat index (IFETCH only)
//   o_dma_rvalid   - returning beat belongs to DMA
//   o_lsu_rvalid   - returning beat belongs to LSU
//   o_if_rvalid    - returning beat belongs to instruction refill
//   o_if_beat      - beat index of the returning refill beat (0 when none)
module ls_ret_pipe
    import spu_ls_pkg::*;
#(
    parameter int unsigned LS_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [1:0]        i_owner,
    input  logic [BEAT_W-1:0] i_beat,
    output logic              o_dma_rvalid,
    output logic              o_lsu_rvalid,
    output logic              o_if_rvalid,
    output logic [BEAT_W-1:0] o_if_beat
);

    ret_tag_t r_pipe [LS_LAT];
    ret_tag_t w_in;
    ret_tag_t w_out;
    logic     w_valid;

    assign w_in = '{valid: i_valid, owner: owner_e'(i_owner), beat: i_beat};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(LS_LAT); k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0] <= w_in;
            for (int k = 1; k < int'(LS_LAT); k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign w_out = r_pipe[LS_LAT-1];

    // Suppress the stage during reset so in-flight beats never produce a response.
    assign w_valid = w_out.valid && !reset;

    assign o_dma_rvalid = w_valid && (w_out.owner == OWN_DMA);
    assign o_lsu_rvalid = w_valid && (w_out.owner == OWN_LSU);
    assign o_if_rvalid  = w_valid && (w_out.owner == OWN_IF);
    assign o_if_beat    = o_if_rvalid ? w_out.beat : '0;

endmodule

// File: rtl/ls_port_arbiter.sv
// ls_port_arbiter: shares the single quadword LS port between DMA, LSU and instruction
// line refill. Fixed priority DMA > LSU > IFETCH; IFETCH jumps to the top once it has
// been denied STARVE_MAX consecutive IDLE cycles. An IFETCH win issues a non-interruptible
// burst of IF_BEATS consecutive quadword reads from the line-aligned address.
//   clk, reset                 - clock, synchronous active-high reset
//   dma_* / lsu_*              - request, write enable, address, write data; gnt; rvalid
//   if_req, if_addr            - line refill request and (unaligned) line address
//   if_gnt                     - pulses with beat 0 of the burst
//   if_rvalid, if_beat, if_done- refill beat return, its index, last-beat pulse
//   ls_en, ls_we, ls_addr, ls_wdata, ls_rdata - LS port (read data LS_LAT cycles later)
//   rdata                      - ls_rdata forwarded unregistered
// Optional build macro LS_ARB_STATS_EN adds 32-bit stat_dma_cnt, stat_lsu_cnt,
// stat_if_cnt (bursts) and stat_starve_cnt (forced promotions) outputs.
module ls_port_arbiter
    import spu_ls_pkg::*;
#(
    parameter int unsigned LS_AW      = LS_AW_DEF,
    parameter int unsigned QW         = QW_DEF,
    parameter int unsigned IF_BEATS   = IF_BEATS_DEF,
    parameter int unsigned LS_LAT     = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [LS_AW-1:0]  dma_addr,
    input  logic [QW-1:0]     dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [LS_AW-1:0]  lsu_addr,
    input  logic [QW-1:0]     lsu_wdata,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    input  logic              if_req,
    input  logic [LS_AW-1:0]  if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [1:0]        if_beat,
    output logic              if_done,
    output logic              ls_en,
    output logic              ls_we,
    output logic [LS_AW-1:0]  ls_addr,
    output logic [QW-1:0]     ls_wdata,
    input  logic [QW-1:0]     ls_rdata,
    output logic [QW-1:0]     rdata
`ifdef LS_ARB_STATS_EN
    ,
    output logic [31:0]       stat_dma_cnt,
    output logic [31:0]       stat_lsu_cnt,
    output logic [31:0]       stat_if_cnt,
    output logic [31:0]       stat_starve_cnt
`endif
);

    localparam int unsigned       SW        = $clog2(STARVE_MAX + 1);
    localparam logic [LS_AW-1:0]  LINE_MASK = ~LS_AW'(IF_BEATS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IF_BEATS - 1);

    arb_state_e        r_state, w_state_nxt;
    logic [BEAT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
    logic [LS_AW-1:0]  r_base, w_base_nxt;
    logic [SW-1:0]     r_starve_cnt, w_starve_nxt;

    logic              w_if_force;
    logic [LS_AW-1:0]  w_if_base;
    ret_tag_t          w_tag;

    assign w_if_force = (r_starve_cnt == SW'(STARVE_MAX)) && if_req;
    assign w_if_base  = if_addr & LINE_MASK;

    // Grants and port drive are combinational; everything is held low during reset.
    always_comb begin
        dma_gnt        = 1'b0;
        lsu_gnt        = 1'b0;
        if_gnt         = 1'b0;
        ls_en          = 1'b0;
        ls_we          = 1'b0;
        ls_addr        = '0;
        ls_wdata       = '0;
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_base_nxt     = r_base;
        w_tag          = '{valid: 1'b0, owner: OWN_NONE, beat: '0};
        if (!reset) begin
            unique case (r_state)
                IDLE: begin
                    if (w_if_force || (if_req && !dma_req && !lsu_req)) begin
                        if_gnt         = 1'b1;
                        ls_en          = 1'b1;
                        ls_addr        = w_if_base;
                        w_tag          = '{valid: 1'b1, owner: OWN_IF, beat: '0};
                        w_base_nxt     = w_if_base;
                        w_beat_cnt_nxt = BEAT_W'(1);
                        w_state_nxt    = BURST;
                    end else if (dma_req) begin
                        dma_gnt  = 1'b1;
                        ls_en    = 1'b1;
                        ls_we    = dma_we;
                        ls_addr  = dma_addr;
                        ls_wdata = dma_wdata;
                        w_tag    = '{valid: !dma_we, owner: OWN_DMA, beat: '0};
                    end else if (lsu_req) begin
                        lsu_gnt  = 1'b1;
                        ls_en    = 1'b1;
                        ls_we    = lsu_we;
                        ls_addr  = lsu_addr;
                        ls_wdata = lsu_wdata;
                        w_tag    = '{valid: !lsu_we, owner: OWN_LSU, beat: '0};
                    end
                end
                BURST: begin
                    // Base is line aligned, so the add never carries out of the line.
                    ls_en          = 1'b1;
                    ls_addr        = r_base + LS_AW'(r_beat_cnt);
                    w_tag          = '{valid: 1'b1, owner: OWN_IF, beat: r_beat_cnt};
                    w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_beat_cnt_nxt = '0;
                        w_state_nxt    = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Counts consecutive IDLE cycles in which a pending refill lost arbitration.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (if_gnt || !if_req) begin
            w_starve_nxt = '0;
        end else if (r_state == IDLE && r_starve_cnt != SW'(STARVE_MAX)) begin
            w_starve_nxt = r_starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_beat_cnt   <= '0;
            r_base       <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_base       <= w_base_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    ls_ret_pipe #(
        .LS_LAT(LS_LAT)
    ) u_ret_pipe (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (w_tag.valid),
        .i_owner     (w_tag.owner),
        .i_beat      (w_tag.beat),
        .o_dma_rvalid(dma_rvalid),
        .o_lsu_rvalid(lsu_rvalid),
        .o_if_rvalid (if_rvalid),
        .o_if_beat   (if_beat)
    );

    assign if_done = if_rvalid && (if_beat == LAST_BEAT);
    assign rdata   = ls_rdata;

`ifdef LS_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_dma_cnt    <= '0;
            stat_lsu_cnt    <= '0;
            stat_if_cnt     <= '0;
            stat_starve_cnt <= '0;
        end else begin
            if (dma_gnt) stat_dma_cnt <= stat_dma_cnt + 32'd1;
            if (lsu_gnt) stat_lsu_cnt <= stat_lsu_cnt + 32'd1;
            if (if_gnt)  stat_if_cnt  <= stat_if_cnt + 32'd1;
            if (if_gnt && w_if_force) stat_starve_cnt <= stat_starve_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ls_port_arbiter.sv
// Bench for ls_port_arbiter: directed scenarios plus a randomized run checked against a
// cycle-level reference model kept here. The LS memory is modelled with a 2-cycle read.
module tb_ls_port_arbiter;

    logic         clk;
    logic         reset;
    logic         dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [13:0]  dma_addr;
    logic [127:0] dma_wdata;
    logic         lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
    logic [13:0]  lsu_addr;
    logic [127:0] lsu_wdata;
    logic         if_req, if_gnt, if_rvalid, if_done;
    logic [13:0]  if_addr;
    logic [1:0]   if_beat;
    logic         ls_en, ls_we;
    logic [13:0]  ls_addr;
    logic [127:0] ls_wdata, ls_rdata, rdata;

    int n_checks;
    int n_pass;

    typedef struct {
        int           due;
        int           own;   // 0 DMA, 1 LSU, 2 IFETCH
        int           beat;
        logic [127:0] data;
    } resp_t;
    resp_t rq[$];

    ls_port_arbiter dut (
        .clk(clk), .reset(reset),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_beat(if_beat), .if_done(if_done),
        .ls_en(ls_en), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pat(input logic [13:0] a);
        return {8{2'b10, a}};
    endfunction

    // LS memory: port sampled mid-cycle, read data appears at the start of cycle t+2.
    logic [127:0] lsmem [0:16383];
    initial begin
        logic         pv1;
        logic [13:0]  pa1;
        logic [127:0] nxt;
        for (int i = 0; i < 16384; i++) lsmem[i] = pat(14'(i));
        pv1 = 1'b0;
        pa1 = '0;
        ls_rdata = '0;
        forever begin
            @(negedge clk);
            nxt = pv1 ? lsmem[pa1] : '0;
            pv1 = ls_en && !ls_we;
            pa1 = ls_addr;
            if (ls_en && ls_we) lsmem[ls_addr] = ls_wdata;
            @(posedge clk);
            ls_rdata = nxt;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0;
        if_req = 0; if_addr = '0;
    endtask

    task automatic drain(input int n);
        idle_inputs();
        repeat (n) cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        dma_req = 1; lsu_req = 1; if_req = 1;
        cyc(); cyc(); #1;
        n_checks++;
        if ({dma_gnt, lsu_gnt, if_gnt} !== 3'b000)
            $display("FAIL reset_gnt: got %b want 000", {dma_gnt, lsu_gnt, if_gnt});
        else n_pass++;
        n_checks++;
        if ({ls_en, ls_we, ls_addr, ls_wdata} !== '0)
            $display("FAIL reset_port: got en=%b we=%b addr=%h want all 0", ls_en, ls_we, ls_addr);
        else n_pass++;
        idle_inputs();
        reset = 1'b0;
        cyc(); #1;
        n_checks++;
        if ({dma_rvalid, lsu_rvalid, if_rvalid, if_done, ls_en} !== 5'b0)
            $display("FAIL reset_release: got %b want 00000",
                     {dma_rvalid, lsu_rvalid, if_rvalid, if_done, ls_en});
        else n_pass++;
    endtask

    task automatic test_ifetch_burst();
        for (int c = 0; c < 7; c++) begin
            cyc();
            if (c == 0) begin if_req = 1; if_addr = 14'h0013; end
            else if_req = 0;
            #1;
            n_checks++;
            if ({if_gnt, ls_en} !== {c == 0, c < 4})
                $display("FAIL burst_gnt_en c=%0d: got %b want %b", c, {if_gnt, ls_en},
                         {c == 0, c < 4});
            else n_pass++;
            if (c < 4) begin
                n_checks++;
                if (ls_addr !== 14'(16 + c))
                    $display("FAIL burst_addr c=%0d: got %h want %h", c, ls_addr, 14'(16 + c));
                else n_pass++;
            end
            n_checks++;
            if ({if_rvalid, if_done} !== {c >= 2 && c <= 5, c == 5})
                $display("FAIL burst_rv c=%0d: got %b want %b", c, {if_rvalid, if_done},
                         {c >= 2 && c <= 5, c == 5});
            else n_pass++;
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if (if_beat !== 2'(c - 2) || rdata !== pat(14'(14 + c)))
                    $display("FAIL burst_beat c=%0d: got beat %0d data %h want beat %0d", c,
                             if_beat, rdata, c - 2);
                else n_pass++;
            end
        end
        drain(4);
    endtask

    task automatic test_priority();
        logic [2:0] eg [6];
        logic [2:0] erv [6];
        eg  = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};
        erv = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b001};
        for (int c = 0; c < 6; c++) begin
            cyc();
            dma_req = (c == 0); dma_we = 0; dma_addr = 14'h0040;
            lsu_req = (c <= 1); lsu_we = 0; lsu_addr = 14'h0041;
            if_req  = (c <= 2); if_addr = 14'h0080;
            #1;
            n_checks++;
            if ({dma_gnt, lsu_gnt, if_gnt} !== eg[c])
                $display("FAIL prio_gnt c=%0d: got %b want %b", c, {dma_gnt, lsu_gnt, if_gnt},
                         eg[c]);
            else n_pass++;
            n_checks++;
            if ({dma_rvalid, lsu_rvalid, if_rvalid} !== erv[c])
                $display("FAIL prio_rv c=%0d: got %b want %b", c,
                         {dma_rvalid, lsu_rvalid, if_rvalid}, erv[c]);
            else n_pass++;
        end
        drain(6);
    endtask

    task automatic test_starvation();
        for (int c = 0; c < 13; c++) begin
            cyc();
            dma_req = 1; dma_we = 1; dma_addr = 14'h0500; dma_wdata = '1;
            if_req = (c <= 8); if_addr = 14'h0200;
            #1;
            n_checks++;
            if ({dma_gnt, if_gnt} !== {c < 8 || c == 12, c == 8})
                $display("FAIL starve c=%0d: got dma=%b if=%b want dma=%b if=%b", c, dma_gnt,
                         if_gnt, c < 8 || c == 12, c == 8);
            else n_pass++;
        end
        drain(6);
    endtask

    task automatic test_burst_lock();
        for (int c = 0; c < 5; c++) begin
            cyc();
            if_req = (c == 0); if_addr = 14'h0300;
            lsu_req = (c >= 1); lsu_we = 1; lsu_addr = 14'h0310; lsu_wdata = '1;
            #1;
            n_checks++;
            if ({lsu_gnt, if_gnt} !== {c == 4, c == 0})
                $display("FAIL lock c=%0d: got lsu=%b if=%b want lsu=%b if=%b", c, lsu_gnt,
                         if_gnt, c == 4, c == 0);
            else n_pass++;
        end
        drain(6);
    endtask

    task automatic test_write_read();
        for (int c = 0; c < 5; c++) begin
            cyc();
            lsu_req = (c <= 1); lsu_we = (c == 0); lsu_addr = 14'h0100;
            lsu_wdata = {16{8'hA5}};
            #1;
            if (c <= 1) begin
                n_checks++;
                if ({lsu_gnt, ls_en, ls_we, ls_addr} !== {1'b1, 1'b1, c == 0, 14'h0100})
                    $display("FAIL wr_rd_port c=%0d: got gnt=%b we=%b addr=%h", c, lsu_gnt,
                             ls_we, ls_addr);
                else n_pass++;
            end
            if (c == 0) begin
                n_checks++;
                if (ls_wdata !== {16{8'hA5}})
                    $display("FAIL wr_data: got %h want %h", ls_wdata, {16{8'hA5}});
                else n_pass++;
            end
            n_checks++;
            if (lsu_rvalid !== (c == 3))
                $display("FAIL wr_rd_rv c=%0d: got %b want %b", c, lsu_rvalid, c == 3);
            else n_pass++;
            if (c == 3) begin
                n_checks++;
                if (rdata !== {16{8'hA5}})
                    $display("FAIL rd_data: got %h want %h", rdata, {16{8'hA5}});
                else n_pass++;
            end
        end
        drain(4);
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 8; c++) begin
            cyc();
            if_req = (c == 0); if_addr = 14'h0400;
            reset = (c == 2);
            #1;
            if (c == 1) begin
                n_checks++;
                if ({ls_en, ls_addr} !== {1'b1, 14'h0401})
                    $display("FAIL rstb_beat1: got en=%b addr=%h want 1 0401", ls_en, ls_addr);
                else n_pass++;
            end
            if (c >= 3) begin
                n_checks++;
                if ({dma_gnt, lsu_gnt, if_gnt, dma_rvalid, lsu_rvalid, if_rvalid, if_done,
                     if_beat, ls_en, ls_we, ls_addr, ls_wdata} !== '0)
                    $display("FAIL rstb_quiet c=%0d: got gnt=%b rv=%b done=%b en=%b addr=%h",
                             c, {dma_gnt, lsu_gnt, if_gnt}, {dma_rvalid, lsu_rvalid, if_rvalid},
                             if_done, ls_en, ls_addr);
                else n_pass++;
            end
        end
        drain(2);
    endtask

    task automatic test_random();
        logic pd, pl, pi, dwe, lwe, burst, e_en, e_we, e_done;
        logic [13:0] da, la, ia, m_base, e_addr, a;
        logic [127:0] dwd, lwd, e_wd, e_data;
        logic [2:0] e_g, e_rv;
        logic [1:0] e_beat;
        int m_left, m_next, m_starve;
        resp_t r;
        logic [127:0] ref_mem [int];
        pd = 0; pl = 0; pi = 0; dwe = 0; lwe = 0;
        da = '0; la = '0; ia = '0; dwd = '0; lwd = '0;
        m_left = 0; m_next = 0; m_starve = 0; m_base = '0;
        rq.delete();
        for (int c = 0; c < 420; c++) begin
            cyc();
            if (c < 400) begin
                if (!pd && $urandom_range(3) == 0) begin
                    pd = 1; dwe = 1'($urandom_range(1)); da = 14'(32'h3000 + $urandom_range(255));
                    dwd = {$urandom, $urandom, $urandom, $urandom};
                end
                if (!pl && $urandom_range(2) == 0) begin
                    pl = 1; lwe = 1'($urandom_range(1)); la = 14'(32'h3000 + $urandom_range(255));
                    lwd = {$urandom, $urandom, $urandom, $urandom};
                end
                if (!pi && $urandom_range(5) == 0) begin
                    pi = 1; ia = 14'(32'h3000 + $urandom_range(255));
                end
            end
            dma_req = pd; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
            lsu_req = pl; lsu_we = lwe; lsu_addr = la; lsu_wdata = lwd;
            if_req = pi; if_addr = ia;
            #1;
            e_rv = 3'b000; e_beat = 2'd0; e_data = '0;
            if (rq.size() > 0 && rq[0].due == c) begin
                r = rq.pop_front();
                e_rv = 3'b100 >> r.own; e_beat = 2'(r.beat); e_data = r.data;
            end
            e_done = (e_rv == 3'b001) && (e_beat == 2'd3);
            e_g = 3'b000; e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
            burst = (m_left > 0);
            if (!burst) begin
                if (pi && (m_starve >= 8 || (!pd && !pl))) begin
                    e_g = 3'b001; m_base = ia & 14'h3FFC; m_next = 0; m_left = 4;
                end else if (pd) begin
                    e_g = 3'b100; e_en = 1; e_we = dwe; e_addr = da; e_wd = dwd;
                end else if (pl) begin
                    e_g = 3'b010; e_en = 1; e_we = lwe; e_addr = la; e_wd = lwd;
                end
            end
            if (!pi || e_g[0]) m_starve = 0;
            else if (!burst && m_starve < 8) m_starve++;
            if (m_left > 0) begin
                e_en = 1; e_addr = m_base + 14'(m_next);
                rq.push_back('{c + 2, 2, m_next,
                    ref_mem.exists(int'(e_addr)) ? ref_mem[int'(e_addr)] : pat(e_addr)});
                m_next++; m_left--;
            end else if (e_en) begin
                a = e_addr;
                if (e_we) ref_mem[int'(a)] = e_wd;
                else rq.push_back('{c + 2, e_g[2] ? 0 : 1, 0,
                    ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a)});
            end
            n_checks++;
            if ({dma_gnt, lsu_gnt, if_gnt} !== e_g)
                $display("FAIL rand_gnt c=%0d: got %b want %b", c, {dma_gnt, lsu_gnt, if_gnt}, e_g);
            else n_pass++;
            n_checks++;
            if ({ls_en, ls_we} !== {e_en, e_we})
                $display("FAIL rand_en_we c=%0d: got %b want %b", c, {ls_en, ls_we}, {e_en, e_we});
            else n_pass++;
            if (e_en) begin
                n_checks++;
                if (ls_addr !== e_addr)
                    $display("FAIL rand_addr c=%0d: got %h want %h", c, ls_addr, e_addr);
                else n_pass++;
            end
            if (e_we) begin
                n_checks++;
                if (ls_wdata !== e_wd)
                    $display("FAIL rand_wdata c=%0d: got %h want %h", c, ls_wdata, e_wd);
                else n_pass++;
            end
            n_checks++;
            if ({dma_rvalid, lsu_rvalid, if_rvalid, if_done} !== {e_rv, e_done})
                $display("FAIL rand_rv c=%0d: got %b want %b", c,
                         {dma_rvalid, lsu_rvalid, if_rvalid, if_done}, {e_rv, e_done});
            else n_pass++;
            if (e_rv != 3'b000) begin
                n_checks++;
                if (rdata !== e_data || (e_rv[0] && if_beat !== e_beat))
                    $display("FAIL rand_data c=%0d: got %h beat %0d want %h beat %0d", c, rdata,
                             if_beat, e_data, e_beat);
                else n_pass++;
            end
            if (e_g[2]) pd = 0;
            if (e_g[1]) pl = 0;
            if (e_g[0]) pi = 0;
        end
        drain(4);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_ifetch_burst();
        test_priority();
        test_starvation();
        test_burst_lock();
        test_write_read();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
